// File: rtl/mac_row_ctrl.sv
// Sequencer for one systolic MAC row: weight load, activation stream, output-valid tracking.
// Optional weight reuse (skip the load phase) is enabled by defining MAC_ROW_CTRL_WREUSE_EN.
module mac_row_ctrl #(
    parameter int unsigned DW      = 8,
    parameter int unsigned WW      = 8,
    parameter int unsigned COLUMN  = 6,
    parameter int unsigned LEN_W   = 10,
    parameter int unsigned MAC_LAT = 2,
    parameter int unsigned CA_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
`ifdef MAC_ROW_CTRL_WREUSE_EN
    input  logic                 reuse_w,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 w_rd_en,
    output logic [CA_W-1:0]      w_rd_addr,
    input  logic [WW-1:0]        w_rd_data,
    output logic [COLUMN*WW-1:0] wi,
    output logic [COLUMN-1:0]    w_en,
    output logic                 x_rd_en,
    output logic [LEN_W-1:0]     x_rd_addr,
    input  logic [DW-1:0]        x_rd_data,
    output logic [DW-1:0]        xi,
    output logic                 x_vld,
    output logic [COLUMN-1:0]    co_vld
);

    // Valid delay line: stage i holds x_vld delayed i+1 cycles.
    localparam int unsigned ShW = MAC_LAT + COLUMN - 1;

    typedef enum logic [2:0] {StIdle, StWload, StStream, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               x_vld_q, x_vld_d;
    logic [ShW-1:0]     vld_sr_q, vld_sr_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        x_vld_d  = (state_q == StStream);
        vld_sr_d = {vld_sr_q[ShW-2:0], x_vld_q};
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d = len;
                    cnt_d = '0;
`ifdef MAC_ROW_CTRL_WREUSE_EN
                    if (reuse_w) state_d = (len == '0) ? StDrain : StStream;
                    else         state_d = StWload;
`else
                    state_d = StWload;
`endif
                end
            end
            StWload: begin
                if (cnt_q == LEN_W'(COLUMN)) begin
                    cnt_d   = '0;
                    state_d = (len_q == '0) ? StDrain : StStream;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStream: begin
                if (cnt_q == len_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                // Long enough for the last x_vld to leave the final co_vld tap.
                if (cnt_q == LEN_W'(MAC_LAT + COLUMN - 1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            len_q    <= '0;
            x_vld_q  <= 1'b0;
            vld_sr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            x_vld_q  <= x_vld_d;
            vld_sr_q <= vld_sr_d;
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        w_rd_en   = (state_q == StWload) && (cnt_q < LEN_W'(COLUMN));
        w_rd_addr = w_rd_en ? cnt_q[CA_W-1:0] : '0;
        // Column k-1 captures the word read in the previous WLOAD cycle.
        for (int c = 0; c < int'(COLUMN); c++) begin
            w_en[c]   = (state_q == StWload) && (cnt_q == LEN_W'(c + 1));
            co_vld[c] = vld_sr_q[MAC_LAT + c - 1];
        end
        x_rd_en   = (state_q == StStream);
        x_rd_addr = x_rd_en ? cnt_q : '0;
        x_vld     = x_vld_q;
        xi        = x_vld_q ? x_rd_data : '0;
    end

    assign wi = {COLUMN{w_rd_data}};

endmodule

// File: tb/tb_mac_row_ctrl.sv
// Directed bench for mac_row_ctrl at default parameters; buffers modelled with 1-cycle read latency.
module tb_mac_row_ctrl;
    localparam int C = 6;
    localparam int M = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [9:0]    len = '0;
    logic          reuse_w = 1'b0;
    logic          busy, done, w_rd_en, x_rd_en, x_vld;
    logic [2:0]    w_rd_addr;
    logic [7:0]    w_rd_data = 8'h5A;
    logic [47:0]   wi;
    logic [5:0]    w_en, co_vld;
    logic [9:0]    x_rd_addr;
    logic [7:0]    x_rd_data = 8'hA5;
    logic [7:0]    xi;

    int checks = 0;
    int errors = 0;

    mac_row_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
`ifdef MAC_ROW_CTRL_WREUSE_EN
        .reuse_w   (reuse_w),
`endif
        .busy      (busy),
        .done      (done),
        .w_rd_en   (w_rd_en),
        .w_rd_addr (w_rd_addr),
        .w_rd_data (w_rd_data),
        .wi        (wi),
        .w_en      (w_en),
        .x_rd_en   (x_rd_en),
        .x_rd_addr (x_rd_addr),
        .x_rd_data (x_rd_data),
        .xi        (xi),
        .x_vld     (x_vld),
        .co_vld    (co_vld)
    );

    always #5 clk = ~clk;

    // Buffer models: data returned one cycle after the read strobe, idle value otherwise.
    always @(posedge clk) begin
        w_rd_data <= w_rd_en ? (8'h30 + {5'd0, w_rd_addr}) : 8'h5A;
        x_rd_data <= x_rd_en ? (8'h10 + x_rd_addr[7:0]) : 8'hA5;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [37:0] act_out();
        return {busy, done, w_rd_en, w_rd_addr, w_en, x_rd_en, x_rd_addr, x_vld, xi, co_vld};
    endfunction

    // Expected outputs at cycle n of a job whose start was sampled at the end of cycle 0.
    function automatic logic [37:0] exp_out(int n, int l, bit r);
        logic       b, d, wre, xre, xv;
        logic [2:0] wa;
        logic [5:0] we, cv;
        logic [9:0] xa;
        logic [7:0] x;
        int s, dr, fin;
        s   = r ? 1 : C + 2;
        dr  = s + l;
        fin = dr + M + C;
        b   = (n >= 1) && (n <= fin);
        d   = (n == fin);
        wre = !r && (n >= 1) && (n <= C);
        wa  = wre ? 3'(n - 1) : 3'd0;
        we  = (!r && (n >= 2) && (n <= C + 1)) ? 6'(1 << (n - 2)) : 6'd0;
        xre = (n >= s) && (n < dr);
        xa  = xre ? 10'(n - s) : 10'd0;
        xv  = (n >= s + 1) && (n <= dr);
        x   = xv ? 8'(8'h10 + (n - s - 1)) : 8'h00;
        for (int c = 0; c < C; c++) cv[c] = (n >= s + 1 + M + c) && (n <= dr + M + c);
        return {b, d, wre, wa, we, xre, xa, xv, x, cv};
    endfunction

    task automatic step(input logic s);
        @(posedge clk);
        #1;
        start = s;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (act_out() !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", act_out());
        end
        rst_n = 1'b1;
        repeat (2) step(1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_job(input int l, input string name);
        logic [37:0] e;
        len = 10'(l);
        for (int n = 0; n <= C + M + l + 12; n++) begin
            step(n == 0);
            if (n == 1) len = 10'h3FF;  // input change while busy must not matter
            e = exp_out(n, l, 1'b0);
            checks++;
            if (act_out() !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h want %h", name, n, act_out(), e);
            end
            if (n >= 2 && n <= C + 1) begin
                checks++;
                if (wi !== {6{8'(8'h30 + n - 2)}}) begin
                    errors++;
                    $display("FAIL %s_wi cycle %0d: got %h want %h", name, n, wi,
                             {6{8'(8'h30 + n - 2)}});
                end
            end
        end
    endtask

    task automatic test_restart_ignored();
        logic [37:0] e;
        len = 10'd4;
        for (int n = 0; n <= 28; n++) begin
            step((n == 0) || (n == 5) || (n == 20));
            e = exp_out(n, 4, 1'b0);
            checks++;
            if (act_out() !== e) begin
                errors++;
                $display("FAIL restart_ignored cycle %0d: got %h want %h", n, act_out(), e);
            end
        end
    endtask

    task automatic test_reset_midjob();
        logic [37:0] e;
        len = 10'd4;
        for (int n = 0; n <= 9; n++) begin
            step(n == 0);
            e = exp_out(n, 4, 1'b0);
            checks++;
            if (act_out() !== e) begin
                errors++;
                $display("FAIL midjob_pre cycle %0d: got %h want %h", n, act_out(), e);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (act_out() !== 38'd0) begin
            errors++;
            $display("FAIL midjob_abort: got %h want 0", act_out());
        end
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (n == 3) rst_n = 1'b1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midjob_no_done %0d: got busy=%b done=%b want 0 0", n, busy, done);
            end
        end
        test_job(4, "after_reset");
    endtask

`ifdef MAC_ROW_CTRL_WREUSE_EN
    task automatic test_reuse();
        logic [37:0] e;
        len     = 10'd3;
        reuse_w = 1'b1;
        for (int n = 0; n <= 16; n++) begin
            step(n == 0);
            if (n == 1) reuse_w = 1'b0;
            e = exp_out(n, 3, 1'b1);
            checks++;
            if (act_out() !== e) begin
                errors++;
                $display("FAIL reuse cycle %0d: got %h want %h", n, act_out(), e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_job(4, "len4");
        test_job(0, "len0");
        test_job(1, "len1");
        test_restart_ignored();
        test_reset_midjob();
`ifdef MAC_ROW_CTRL_WREUSE_EN
        test_reuse();
        test_job(2, "load_after_reuse");
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
